bus_demultiplexor: RTL

- Registered 1-to-2 demultiplexor: the inverse of the 2:1 select path.
- Accepts one data word per handshake on a single input stream and steers it, by a select bit, into one of two output channels.
- Each channel has its own 2-entry buffer and valid/ready handshake, so a stalled consumer does not block the other channel.
- Sits between the memory data bus and its two consumers: instruction path (channel 0) and operand/accumulator path (channel 1).

---
 rtl/bus_demux_pkg.sv | 15 +
 rtl/bus_demux_if.sv | 38 +++
 rtl/demux_chan_buf.sv | 58 +++++
 rtl/bus_demultiplexor.sv | 58 +++++
 4 files changed

// File: rtl/bus_demux_pkg.sv
// Shared definitions for the bus demultiplexor slice.
//   DEMUX_DEPTH : entries per channel buffer
//   count_t     : per-channel occupancy type (0..DEMUX_DEPTH)
//   CH_INSTR / CH_DATA : in_sel encodings for the two consumers
package bus_demux_pkg;

    localparam int unsigned DEMUX_DEPTH = 2;
    localparam int unsigned COUNT_W     = 2;

    typedef logic [COUNT_W-1:0] count_t;

    localparam logic CH_INSTR = 1'b0;
    localparam logic CH_DATA  = 1'b1;

endpackage

// File: rtl/bus_demux_if.sv
// Handshake bundle between the memory data bus and its two consumers.
//   in_*         : single input stream (data, select, valid/ready)
//   out0_* out1_*: per-channel head word, valid/ready and occupancy
// master: source/consumer side. slave: the demultiplexor.
interface bus_demux_if
    import bus_demux_pkg::*;
#(
    parameter int unsigned WIDTH = 5
);

    logic [WIDTH-1:0] in_data;
    logic             in_sel;
    logic             in_valid;
    logic             in_ready;

    logic [WIDTH-1:0] out0_data;
    logic             out0_valid;
    logic             out0_ready;
    count_t           out0_count;

    logic [WIDTH-1:0] out1_data;
    logic             out1_valid;
    logic             out1_ready;
    count_t           out1_count;

    modport master (
        output in_data, in_sel, in_valid, out0_ready, out1_ready,
        input  in_ready, out0_data, out0_valid, out0_count,
               out1_data, out1_valid, out1_count
    );

    modport slave (
        input  in_data, in_sel, in_valid, out0_ready, out1_ready,
        output in_ready, out0_data, out0_valid, out0_count,
               out1_data, out1_valid, out1_count
    );

endinterface

// File: rtl/demux_chan_buf.sv
// Two-entry synchronous FIFO used as one demultiplexor output channel.
//   clk, rst  : clock, synchronous active-high reset
//   push      : write push_data at the tail this cycle (caller guarantees not full)
//   push_data : word to write
//   pop_ready : consumer ready; pops only when the buffer holds data
//   head      : oldest word (registered storage, no path from push_data)
//   valid     : buffer non-empty
//   count     : occupancy 0..DEMUX_DEPTH
module demux_chan_buf
    import bus_demux_pkg::*;
#(
    parameter int unsigned WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop_ready,
    output logic [WIDTH-1:0] head,
    output logic             valid,
    output count_t           count
);

    logic [WIDTH-1:0] mem [DEMUX_DEPTH];
    logic             wr_ptr;
    logic             rd_ptr;
    logic             pop;

    assign valid = (count != '0);
    assign pop   = valid && pop_ready;
    assign head  = mem[rd_ptr];

    // Storage, pointers and occupancy; simultaneous push/pop keeps count.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEMUX_DEPTH); i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            unique case ({push, pop})
                2'b10:   count <= count + COUNT_W'(1);
                2'b01:   count <= count - COUNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bus_demultiplexor.sv
// Registered 1-to-2 demultiplexor: steers each accepted input word by in_sel
// into channel 0 (instruction path) or channel 1 (operand path), each with its
// own 2-entry buffer so one stalled consumer never blocks the other.
//   clk, rst : clock, synchronous active-high reset
//   bus      : bus_demux_if slave modport (input stream + two output channels)
module bus_demultiplexor
    import bus_demux_pkg::*;
#(
    parameter int unsigned width = 5,
    parameter int unsigned depth = DEMUX_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    bus_demux_if.slave  bus
);

    count_t cnt0;
    count_t cnt1;
    count_t sel_cnt;
    logic   fire;
    logic   push0;
    logic   push1;

    // Ready depends only on the selected channel's registered count, so a
    // full channel refuses even if it pops this cycle.
    assign sel_cnt      = (bus.in_sel == CH_DATA) ? cnt1 : cnt0;
    assign bus.in_ready = !rst && (sel_cnt < COUNT_W'(depth));

    assign fire  = bus.in_valid && bus.in_ready;
    assign push0 = fire && (bus.in_sel == CH_INSTR);
    assign push1 = fire && (bus.in_sel == CH_DATA);

    demux_chan_buf #(.WIDTH(width)) u_chan0 (
        .clk       (clk),
        .rst       (rst),
        .push      (push0),
        .push_data (bus.in_data),
        .pop_ready (bus.out0_ready),
        .head      (bus.out0_data),
        .valid     (bus.out0_valid),
        .count     (cnt0)
    );

    demux_chan_buf #(.WIDTH(width)) u_chan1 (
        .clk       (clk),
        .rst       (rst),
        .push      (push1),
        .push_data (bus.in_data),
        .pop_ready (bus.out1_ready),
        .head      (bus.out1_data),
        .valid     (bus.out1_valid),
        .count     (cnt1)
    );

    assign bus.out0_count = cnt0;
    assign bus.out1_count = cnt1;

endmodule
